// File: rtl/tick_gen.sv
// Run-control and clock-enable generator for the mod-8 counter chain.
// Conditions run/step buttons, prescales clk into enable pulses, halts on terminal count.
module tick_gen #(
  parameter int DIV       = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  input  logic auto_stop,
  input  logic tc_in,
  output logic en_out,
  output logic running,
  output logic halted
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // Button conditioning; index 0 = run, index 1 = step.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      press_q, press_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  logic press_run;
  logic press_step;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             en_q, en_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             halt_cond;

  assign btn_raw = {btn_step, btn_run};

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    level_d  = level_q;
    press_d  = '0;
    db_cnt_d = '{default: '0};
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
          // Only a 0->1 flip of the debounced level is a press.
          press_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      db_cnt_q <= '{default: '0};
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign press_run  = press_q[0];
  assign press_step = press_q[1];

  // tc_in is only meaningful during a cycle that carries an enable pulse.
  assign halt_cond = auto_stop & tc_in & en_q;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    en_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_run) begin
          state_d = RUN;
        end else if (press_step) begin
          en_d = 1'b1;
        end
      end
      RUN: begin
        if (halt_cond) begin
          state_d = HALT;
        end else if (press_run) begin
          state_d = IDLE;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          en_d      = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      HALT: begin
        if (press_run) begin
          state_d   = RUN;
          div_cnt_d = '0;
        end else if (press_step) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    running_d = (state_d == RUN);
    halted_d  = (state_d == HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      en_q      <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      en_q      <= en_d;
      running_q <= running_d;
      halted_q  <= halted_d;
    end
  end

  assign en_out  = en_q;
  assign running = running_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: behavioural model checked every cycle,
// plus directed scenarios with hand-derived expectations and a random phase.
module tb_tick_gen;

  localparam int DIV = 4;
  localparam int DB  = 3;
  localparam int HL  = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic auto_stop = 1'b0;
  logic tc_in;
  logic en_out, running, halted;
  logic [2:0] chain_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int en_seen = 0;
  int run_rises = 0;
  bit run_prev = 1'b0;

  always #5 clk = ~clk;

  tick_gen #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .auto_stop(auto_stop),
    .tc_in    (tc_in),
    .en_out   (en_out),
    .running  (running),
    .halted   (halted)
  );

  // Downstream mod-8 chain; tc is the raw "count is 7" level.
  always @(posedge clk or posedge rst) begin
    if (rst) chain_cnt <= 3'd0;
    else if (en_out) chain_cnt <= chain_cnt + 3'd1;
  end
  assign tc_in = (chain_cnt == 3'd7);

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a button press is recognised when the last DB synced
  // samples all disagree with the debounced level; the prescaler is a
  // countdown of edges remaining until the next pulse.
  typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_rem  = DIV;
  bit    m_en   = 1'b0;
  bit    m_level [2];
  bit    m_pend  [2];
  bit    m_hist  [2][HL];

  always @(posedge clk) begin
    bit pr, ps, tc, nen, diff;
    bit raw [2];
    if (rst) begin
      m_mode = M_IDLE;
      m_rem  = DIV;
      m_en   = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_level[b] = 1'b0;
        m_pend[b]  = 1'b0;
        for (int k = 0; k < HL; k++) m_hist[b][k] = 1'b0;
      end
    end else begin
      pr = m_pend[0];
      ps = m_pend[1];
      tc = tc_in && m_en && auto_stop;
      raw[0] = btn_run;
      raw[1] = btn_step;
      for (int b = 0; b < 2; b++) begin
        for (int k = HL - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
        m_hist[b][0] = raw[b];
        diff = 1'b1;
        for (int k = 2; k <= DB + 1; k++) if (m_hist[b][k] == m_level[b]) diff = 1'b0;
        m_pend[b] = 1'b0;
        if (diff) begin
          m_level[b] = !m_level[b];
          m_pend[b]  = m_level[b];
        end
      end
      nen = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (pr) m_mode = M_RUN;
          else if (ps) nen = 1'b1;
        end
        M_RUN: begin
          if (tc) m_mode = M_HALT;
          else if (pr) m_mode = M_IDLE;
          else begin
            m_rem--;
            if (m_rem == 0) begin
              nen = 1'b1;
              m_rem = DIV;
            end
          end
        end
        default: begin
          if (pr) begin
            m_mode = M_RUN;
            m_rem  = DIV;
          end else if (ps) m_mode = M_IDLE;
        end
      endcase
      m_en = nen;
    end
    #1;
    chk("en_out",  int'(en_out),  int'(m_en));
    chk("running", int'(running), int'(m_mode == M_RUN));
    chk("halted",  int'(halted),  int'(m_mode == M_HALT));
    if (en_out) en_seen++;
    if (running && !run_prev) run_rises++;
    run_prev = running;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int which, input int hold);
    @(negedge clk);
    if (which == 0) btn_run = 1'b1; else btn_step = 1'b1;
    repeat (hold) @(negedge clk);
    if (which == 0) btn_run = 1'b0; else btn_step = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic edges_to_en(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (en_out) begin n = i; break; end
    end
  endtask

  task automatic edges_to_level(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && running) || (which == 1 && halted)) begin n = i; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, e0, r0;
    bit ok;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Run latency: running rises DB+3 edges after a clean raw rise.
    @(negedge clk);
    btn_run = 1'b1;
    edges_to_level(0, 20, n);
    chk("run_latency", n, DB + 3);
    @(negedge clk);
    btn_run = 1'b0;
    edges_to_en(40, n);
    chk("first_en_found", int'(n > 0), 1);
    edges_to_en(40, n);
    chk("en_period", n, DIV);

    // Pause, then three single steps in IDLE.
    press_btn(0, 6);
    cyc(12);
    chk("paused", int'(running), 0);
    e0 = en_seen; r0 = run_rises;
    repeat (3) begin
      press_btn(1, 6);
      cyc(6);
    end
    chk("step_pulses", en_seen - e0, 3);
    chk("step_no_run", run_rises - r0, 0);

    // Resume from held count; a step in RUN must not disturb the period.
    press_btn(0, 6);
    cyc(10);
    press_btn(1, 6);
    cyc(4);
    edges_to_en(40, n);
    edges_to_en(40, n);
    chk("period_after_step", n, DIV);

    // Reset while a pulse is on the wire.
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (en_out) begin ok = 1'b1; break; end
    end
    chk("en_before_rst", int'(ok), 1);
    rst = 1'b1;
    #1;
    chk("rst_en_out",  int'(en_out),  0);
    chk("rst_running", int'(running), 0);
    chk("rst_halted",  int'(halted),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e0 = en_seen;
    cyc(20);
    chk("quiet_after_rst", en_seen - e0, 0);

    // Bounce with 2-cycle runs must not register; a steady level must, once.
    e0 = en_seen; r0 = run_rises;
    for (int i = 0; i < 5; i++) begin
      btn_run = 1'b1; cyc(2);
      btn_run = 1'b0; cyc(2);
    end
    chk("bounce_no_en",  en_seen - e0, 0);
    chk("bounce_no_run", run_rises - r0, 0);
    btn_run = 1'b1; cyc(10);
    btn_run = 1'b0; cyc(6);
    chk("bounce_one_run", run_rises - r0, 1);
    press_btn(0, 6);
    cyc(8);

    // Auto-stop after the 8th pulse of a fresh chain.
    do_reset();
    auto_stop = 1'b1;
    e0 = en_seen;
    press_btn(0, 6);
    edges_to_level(1, 100, n);
    chk("halt_reached", int'(n > 0), 1);
    @(negedge clk);
    chk("pulses_to_halt", en_seen - e0, 8);
    chk("halt_not_running", int'(running), 0);
    e0 = en_seen;
    cyc(50);
    chk("halt_quiet", en_seen - e0, 0);
    chk("halt_held", int'(halted), 1);

    // HALT -> RUN restarts the prescaler from zero.
    btn_run = 1'b1;
    edges_to_level(0, 20, n);
    chk("halt_resume", int'(n > 0), 1);
    edges_to_en(20, n);
    chk("halt_resume_first_en", n, DIV);
    @(negedge clk);
    btn_run = 1'b0;

    // Press lands on the halting pulse: halt must win.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en_out && chain_cnt == 3'd5) begin ok = 1'b1; break; end
    end
    chk("found_chain5", int'(ok), 1);
    repeat (3) @(negedge clk);
    btn_run = 1'b1;
    cyc(6);
    btn_run = 1'b0;
    cyc(10);
    chk("halt_wins", int'(halted), 1);

    // Step in HALT returns to IDLE without a pulse.
    e0 = en_seen;
    press_btn(1, 6);
    cyc(8);
    chk("halt_step_idle", int'(halted), 0);
    chk("halt_step_not_run", int'(running), 0);
    chk("halt_step_no_pulse", en_seen - e0, 0);

    // Run and step together in IDLE: RUN, step dropped.
    @(negedge clk);
    btn_run = 1'b1; btn_step = 1'b1;
    edges_to_level(0, 20, n);
    chk("both_enter_run", int'(n > 0), 1);
    chk("both_no_step", int'(en_out), 0);
    cyc(4);
    btn_run = 1'b0; btn_step = 1'b0;
    cyc(8);
    press_btn(0, 6);
    cyc(8);

    // auto_stop = 0: pulses continue past roll-over.
    do_reset();
    auto_stop = 1'b0;
    e0 = en_seen;
    press_btn(0, 6);
    cyc(60);
    chk("free_run_past_rollover", int'((en_seen - e0) > 8), 1);
    chk("free_run_not_halted", int'(halted), 0);

    // Random phase, checked cycle by cycle against the model.
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) do_reset();
      else if (r < 3) auto_stop = 1'($urandom_range(0, 1));
      btn_run  = ($urandom_range(0, 3) == 0);
      btn_step = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 8));
    end
    btn_run = 1'b0;
    btn_step = 1'b0;
    cyc(10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Run-control and clock-enable generator that sits directly upstream of the cascaded mod-8 counter chain. Conditions two raw push-buttons (run/pause toggle, single-step), prescales the system clock into one-cycle enable pulses, and drives the first counter's enable input. It consumes the chain's terminal-count output so it can halt automatically at roll-over.

## Interface
- DIV, default 100_000_000: prescale ratio; one enable pulse per DIV cycles while running; legal range ≥ 2.
- DB_CYCLES, default 1_000_000: debounce stability window in clock cycles; legal range ≥ 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- btn_run  in  1  raw run/pause button, asynchronous, active-high.
- btn_step  in  1  raw single-step button, asynchronous, active-high.
- auto_stop  in  1  level; when 1, a terminal count from the chain halts the block.
- tc_in  in  1  terminal-count input from the downstream chain; combinational, qualified by en_out.
- en_out  out  1  registered one-cycle enable pulse to the counter chain.
- running  out  1  registered; 1 only in RUN.
- halted  out  1  registered; 1 only in HALT.

## Operation
- Button conditioning, identical per button:
  - 2-flop synchronizer.
  - Debounce counter of width $clog2(DB_CYCLES). It increments each cycle the synchronizer output differs from the debounced level, and clears when they match.
  - When the counter equals DB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Rising edge of the debounced level produces an internal one-cycle press pulse (press_run, press_step). Release generates no pulse.
- Prescaler div_cnt, width $clog2(DIV):
  - Counts only in RUN.
  - At div_cnt == DIV-1 it wraps to 0 and en_out is set for the next cycle.
  - Holds its value in IDLE.
  - Clears on entry to RUN from HALT.
- FSM, 2-bit, states IDLE / RUN / HALT; reset state is IDLE.
  - IDLE, press_run: go to RUN. div_cnt resumes from its held value.
  - IDLE, press_step (no press_run): stay in IDLE; en_out = 1 for exactly one cycle.
  - IDLE, press_run and press_step in the same cycle: go to RUN; the step is dropped.
  - RUN, press_run: go to IDLE (pause). No further en_out is issued. press_step is ignored.
  - RUN, tc_in && en_out && auto_stop: go to HALT. The pulse carrying tc_in is delivered; no more follow.
  - RUN, press_run and the halt condition in the same cycle: go to HALT (halt wins).
  - HALT, press_run: go to RUN with div_cnt cleared.
  - HALT, press_step: go to IDLE; no pulse is issued.
  - HALT, both in the same cycle: press_run wins.
- auto_stop = 0: tc_in is ignored; the chain wraps freely.
- en_out is never high two consecutive cycles when DIV ≥ 2. A step pulse cannot coincide with a prescaler pulse, because stepping happens only in IDLE.

## Timing
- Reset values (asserted asynchronously, within the same cycle as rst rising):
  - en_out = 0, running = 0, halted = 0.
  - State = IDLE, div_cnt = 0.
  - Debounced levels = 0, debounce counters = 0, synchronizer flops = 0.
- Reset mid-pulse: en_out drops immediately, with no completion.
- Release from reset: first possible transition on the first clk edge with rst low.
- Button latency: raw rise stable before edge 1 → debounced level flips at edge 1+DB_CYCLES+1 → FSM acts at edge DB_CYCLES+3.
  - running rises after edge DB_CYCLES+3.
  - A step en_out is high in the cycle after edge DB_CYCLES+3.
- Bounce shorter than DB_CYCLES consecutive stable cycles produces no press pulse.
- RUN entry from IDLE with div_cnt = k: first en_out is high in the cycle after the (DIV-k)th edge in RUN.
- RUN entry from HALT: first en_out after DIV edges. Steady period is exactly DIV cycles.
- Halt: halted = 1 in the cycle after the en_out/tc_in cycle; running = 0 in that same cycle.

## Test plan
Parameters for all scenarios: DIV=4, DB_CYCLES=3.
- Reset: assert rst mid-RUN while en_out = 1 → en_out, running, halted all 0 immediately; after release, 20 cycles with no buttons → en_out stays 0.
- Run and pause: clean btn_run press → running = 1 six edges after raw rise; en_out pulses every 4 cycles, 1 cycle wide; second press → running = 0; div_cnt held, so the next press gives first pulse after 4-k cycles.
- Debounce: btn_run toggles with high/low runs of 2 cycles for 20 cycles, then stays high → exactly one press (one RUN entry) and no spurious en_out during the bounce.
- Single step: in IDLE press btn_step three times → exactly three single-cycle en_out pulses, running stays 0; btn_step pressed in RUN → no extra pulse and period unchanged.
- Auto-stop: auto_stop = 1, model mod-8 chain driving tc_in → after 8 en_out pulses, halted = 1 in the next cycle and en_out stays 0 for 50 cycles; auto_stop = 0 repeat → pulses continue past roll-over.
- Simultaneous events:
  - press_run with press_step in IDLE → RUN, no step pulse.
  - press_run in the halt-condition cycle → HALT.
  - press_run in HALT → RUN, first en_out exactly 4 cycles later.
